// File: rtl/fe_tobytes_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fe_pkg
//  Description : Shared constants and types for the GF(2^255-19) limb
//                domain (10 signed limbs, 26/25-bit alternating radix).
//  Revision    : 1.0 - initial release
// ============================================================================
package fe_pkg;

    localparam int NUM_LIMBS = 10;
    localparam int ACC_W     = 40;

    // Limb radix widths, alternating 26/25 starting with limb 0.
    localparam int LIMB_W   [NUM_LIMBS] = '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};

    // Bit position of each limb inside the 255-bit value.
    localparam int LIMB_OFF [NUM_LIMBS] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

    // p = 2^255 - 19 in limb form.
    localparam logic [25:0] P_LIMBS [NUM_LIMBS] = '{
        26'h3FFFFED, 26'h1FFFFFF, 26'h3FFFFFF, 26'h1FFFFFF, 26'h3FFFFFF,
        26'h1FFFFFF, 26'h3FFFFFF, 26'h1FFFFFF, 26'h3FFFFFF, 26'h1FFFFFF
    };

    typedef logic signed [32*NUM_LIMBS-1:0] fe_limbs_t;
    typedef logic        [255:0]            fe_bytes_t;
    typedef logic signed [ACC_W-1:0]        acc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QCALC = 3'd1,
        ST_FOLD  = 3'd2,
        ST_CARRY = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fe_tobytes_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fe_tobytes_seq_if
//  Description : Input (limbs) and output (bytes) valid/ready streams of the
//                limb-to-byte encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fe_tobytes_seq_if;
    import fe_pkg::*;

    logic      in_valid;
    logic      in_ready;
    fe_limbs_t in_f;
    logic      out_valid;
    logic      out_ready;
    fe_bytes_t out_bytes;

    // Producer of limbs / consumer of bytes.
    modport master (
        output in_valid, in_f, out_ready,
        input  in_ready, out_valid, out_bytes
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_f, out_ready,
        output in_ready, out_valid, out_bytes
    );
endinterface
`default_nettype wire

// File: rtl/fe_tobytes_seq_carry_step.sv
`default_nettype none
// ============================================================================
//  Module      : fe_carry_step
//  Description : Single-limb carry step: sum = h + carry_in, carry_out is the
//                floor of sum / 2^w and the limb keeps the low w bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module fe_carry_step
    import fe_pkg::*;
(
    input  acc_t i_h,
    input  acc_t i_cin,
    input  logic i_w25,     // 1: 25-bit limb (odd index), 0: 26-bit limb
    output acc_t o_cout,
    output acc_t o_limb
);

    acc_t w_sum;

    assign w_sum  = i_h + i_cin;
    // Arithmetic shift gives floor division for negative sums as well.
    assign o_cout = i_w25 ? (w_sum >>> 25) : (w_sum >>> 26);
    // sum - (cout << w) is exactly the low w bits of the sum.
    assign o_limb = i_w25 ? {15'b0, w_sum[24:0]} : {14'b0, w_sum[25:0]};

endmodule
`default_nettype wire

// File: rtl/fe_tobytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fe_tobytes_seq
//  Description : Sequential encoder from signed 10-limb field elements to the
//                canonical little-endian 32-byte encoding mod 2^255-19.
//                Phases: QCALC (quotient estimate), FOLD (add 19*q),
//                CARRY (normalise limbs), OUT (hold result until taken).
//  Revision    : 1.0 - initial release
// ============================================================================
module fe_tobytes_seq
    import fe_pkg::*;
#(
    parameter int LIMBS_PER_CYCLE = 1   // 1, 2 or 5
)
(
    input  logic              clk,
    input  logic              rst,
    fe_tobytes_seq_if.slave   bus
);

    localparam int   PH         = NUM_LIMBS / LIMBS_PER_CYCLE;
    localparam acc_t C_NINETEEN = 40'sd19;
    localparam acc_t C_HALF     = 40'sd16777216;   // 2^24, rounds the q estimate

    state_t     r_state;
    state_t     w_state_nxt;
    acc_t       r_h [NUM_LIMBS];
    acc_t       r_q;            // quotient in QCALC, running carry in CARRY
    logic [3:0] r_cnt;
    logic       w_last;
    acc_t       w_h9_in;
    acc_t       w_q0;
    fe_bytes_t  w_bytes;

    logic [3:0] w_idx  [LIMBS_PER_CYCLE];
    acc_t       w_cin  [LIMBS_PER_CYCLE+1];
    acc_t       w_limb [LIMBS_PER_CYCLE];

    assign w_last  = (r_cnt == 4'(PH - 1));
    assign w_h9_in = acc_t'($signed(bus.in_f[32*9 +: 32]));
    assign w_q0    = (C_NINETEEN * w_h9_in + C_HALF) >>> 25;

    // Chain of carry steps; the same chain serves the quotient pass and the
    // final normalisation pass, only the write-back differs.
    assign w_cin[0] = r_q;
    for (genvar k = 0; k < LIMBS_PER_CYCLE; k++) begin : g_step
        assign w_idx[k] = 4'(r_cnt * 4'(LIMBS_PER_CYCLE)) + 4'(k);
        fe_carry_step u_step (
            .i_h    (r_h[w_idx[k]]),
            .i_cin  (w_cin[k]),
            .i_w25  (w_idx[k][0]),
            .o_cout (w_cin[k+1]),
            .o_limb (w_limb[k])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_valid)  w_state_nxt = ST_QCALC;
            ST_QCALC: if (w_last)        w_state_nxt = ST_FOLD;
            ST_FOLD:                     w_state_nxt = ST_CARRY;
            ST_CARRY: if (w_last)        w_state_nxt = ST_OUT;
            ST_OUT:   if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Limb, quotient/carry and step-counter datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LIMBS; i++) begin
                r_h[i] <= '0;
            end
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < NUM_LIMBS; i++) begin
                            r_h[i] <= acc_t'($signed(bus.in_f[32*i +: 32]));
                        end
                        r_q   <= w_q0;
                        r_cnt <= '0;
                    end
                end
                ST_QCALC: begin
                    r_q   <= w_cin[LIMBS_PER_CYCLE];
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                end
                ST_FOLD: begin
                    r_h[0] <= r_h[0] + C_NINETEEN * r_q;
                    r_q    <= '0;       // carry into limb 0 is zero
                    r_cnt  <= '0;
                end
                ST_CARRY: begin
                    for (int k = 0; k < LIMBS_PER_CYCLE; k++) begin
                        r_h[w_idx[k]] <= w_limb[k];
                    end
                    // Carry out of limb 9 lands here and is never used.
                    r_q   <= w_cin[LIMBS_PER_CYCLE];
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Pack the normalised limbs LSB-first into the 255-bit value; bit 255 is 0.
    always_comb begin
        w_bytes = '0;
        for (int i = 0; i < NUM_LIMBS; i++) begin
            w_bytes = w_bytes |
                ((fe_bytes_t'(r_h[i][25:0]) &
                  ((fe_bytes_t'(1) << LIMB_W[i]) - fe_bytes_t'(1))) << LIMB_OFF[i]);
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.out_bytes = w_bytes;

endmodule
`default_nettype wire

// File: tb/tb_fe_tobytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fe_tobytes_seq
//  Description : Self-checking bench for fe_tobytes_seq: directed vector
//                table, throughput, backpressure, mid-operation reset and
//                random elements against an integer mod-p reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fe_tobytes_seq;
    import fe_pkg::*;

    localparam int LPC    = 1;
    localparam int PH     = NUM_LIMBS / LPC;
    localparam int LAT    = 2*PH + 2;
    localparam int PERIOD = 2*PH + 3;

    typedef struct {
        string     name;
        fe_limbs_t f;
        fe_bytes_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fe_tobytes_seq_if bus();

    fe_tobytes_seq #(.LIMBS_PER_CYCLE(LPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;
    int        acc_cyc  [$];
    int        rise_cyc [$];
    int        hs_cyc   [$];
    fe_bytes_t hs_data  [$];
    logic      prev_ov = 1'b0;

    // Edge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampling midway between rising edges.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.out_valid && !prev_ov) rise_cyc.push_back(cyc);
        if (bus.out_valid && bus.out_ready) begin
            hs_data.push_back(bus.out_bytes);
            hs_cyc.push_back(cyc);
        end
        prev_ov <= bus.out_valid;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer value of the limbs reduced into [0, p).
    function automatic fe_bytes_t model(input fe_limbs_t f);
        logic signed [271:0] v;
        logic signed [271:0] t;
        logic signed [271:0] p;
        logic signed [31:0]  l;
        p = (272'sd1 <<< 255) - 272'sd19;
        v = '0;
        for (int i = 0; i < NUM_LIMBS; i++) begin
            l = f[32*i +: 32];
            t = l;
            v = v + (t <<< LIMB_OFF[i]);
        end
        for (int n = 0; n < 16 && v < 0; n++) v = v + p;
        for (int n = 0; n < 16 && v >= p; n++) v = v - p;
        return v[255:0];
    endfunction

    // mode 0: non-negative limbs of full width; 1: signed limbs;
    // 2: values within a few units of p.
    function automatic fe_limbs_t rand_fe(input int mode);
        fe_limbs_t        f;
        int               w;
        int unsigned      r;
        int               mag;
        logic signed [31:0] l;
        f = '0;
        for (int i = 0; i < NUM_LIMBS; i++) begin
            w = LIMB_W[i];
            r = $urandom;
            case (mode)
                0: l = 32'(r & ((32'd1 << w) - 32'd1));
                1: begin
                    mag = int'(r & ((32'd1 << (w - 1)) - 32'd1));
                    l   = r[31] ? -mag : mag;
                end
                default: begin
                    l = 32'(P_LIMBS[i]);
                    if (i == 0) l = l - 32'sd20 + 32'($urandom_range(0, 38));
                end
            endcase
            f[32*i +: 32] = l;
        end
        return f;
    endfunction

    task automatic send(input fe_limbs_t f);
        int n = 0;
        bus.in_f     = f;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_in_time", 256'(n < 200), 256'(1));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit rnd_ready, output fe_bytes_t data);
        int start = hs_data.size();
        int n     = 0;
        while (hs_data.size() == start && n < 400) begin
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        chk("output_in_time", 256'(n < 400), 256'(1));
        data = (hs_data.size() > start) ? hs_data[$] : '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t      tbl [7];
        fe_limbs_t f;
        fe_limbs_t f2;
        fe_bytes_t got;
        fe_bytes_t e;
        fe_bytes_t exp3 [3];
        int        base;
        int        hbase;
        int        nrise;
        int        n;

        bus.in_valid  = 1'b0;
        bus.in_f      = '0;
        bus.out_ready = 1'b0;

        // Directed vectors with hand-derived expectations.
        tbl[0].name = "zero";        tbl[0].f = '0;            tbl[0].exp = '0;
        tbl[1].name = "one";         tbl[1].f = 320'd1;        tbl[1].exp = 256'd1;
        f = '0;
        for (int i = 0; i < NUM_LIMBS; i++) f[32*i +: 32] = 32'(P_LIMBS[i]);
        tbl[2].name = "p";           tbl[2].f = f;             tbl[2].exp = '0;
        f[31:0] = 32'h03FF_FFEE;
        tbl[3].name = "p_plus_1";    tbl[3].f = f;             tbl[3].exp = 256'd1;
        f = '0; f[31:0] = 32'hFFFF_FFFF;
        tbl[4].name = "minus_one";   tbl[4].f = f;
        tbl[4].exp = {8'h7F, {30{8'hFF}}, 8'hEC};
        f = '0; f[32*9 +: 32] = 32'd1; e = '0; e[230] = 1'b1;
        tbl[5].name = "two_pow_230"; tbl[5].f = f;             tbl[5].exp = e;
        f = '0; f[32*9 +: 32] = 32'h0200_0000;
        tbl[6].name = "two_pow_255"; tbl[6].f = f;             tbl[6].exp = 256'd19;

        // Reset state.
        #1;
        chk("rst_in_ready",  256'(bus.in_ready),  256'(1));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_out_bytes", bus.out_bytes, '0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Table: value and latency (accept sample to first out_valid sample).
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].f);
            wait_out(1'b0, got);
            chk(tbl[i].name, got, tbl[i].exp);
            chk({tbl[i].name, "_latency"}, 256'(rise_cyc[$] - acc_cyc[$]), 256'(LAT));
        end

        // Back-to-back elements with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        base  = acc_cyc.size();
        hbase = hs_data.size();
        for (int i = 0; i < 3; i++) begin
            f = rand_fe(0);
            exp3[i] = model(f);
            send(f);
        end
        wait_out(1'b0, got);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("burst%0d_data", i), hs_data[hbase + i], exp3[i]);
        end
        chk("burst_period_a", 256'(acc_cyc[base + 1] - acc_cyc[base]),     256'(PERIOD));
        chk("burst_period_b", 256'(acc_cyc[base + 2] - acc_cyc[base + 1]), 256'(PERIOD));

        // Backpressure: output held, new input refused until it is taken.
        bus.out_ready = 1'b0;
        f = '0; f[31:0] = 32'd5;
        send(f);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_out_valid", 256'(bus.out_valid), 256'(1));
        f2 = '0; f2[63:32] = 32'd3;
        bus.in_f     = f2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_bytes", bus.out_bytes, 256'd5);
            chk("bp_hold_valid", 256'(bus.out_valid), 256'(1));
            chk("bp_in_ready",   256'(bus.in_ready),  256'(0));
        end
        base  = acc_cyc.size();
        hbase = hs_cyc.size();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("bp_data", hs_data[hbase], 256'd5);
        chk("bp_accept_gap", 256'(acc_cyc[base] - hs_cyc[hbase]), 256'(1));
        wait_out(1'b0, got);
        e = '0; e[27:26] = 2'd3;
        chk("bp_second", got, e);

        // Reset while CARRY is at step 5: element dropped, no output pulse.
        f = '0; f[31:0] = 32'd1;
        send(f);
        repeat (PH + 6) tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 256'(bus.out_valid), 256'(0));
        chk("abort_out_bytes", bus.out_bytes, '0);
        tick();
        tick();
        rst   = 1'b0;
        nrise = rise_cyc.size();
        repeat (30) tick();
        chk("abort_no_pulse", 256'(rise_cyc.size()), 256'(nrise));
        chk("abort_in_ready", 256'(bus.in_ready), 256'(1));
        send(f);
        wait_out(1'b0, got);
        chk("after_abort", got, 256'd1);
        chk("after_abort_latency", 256'(rise_cyc[$] - acc_cyc[$]), 256'(LAT));

        // Random elements with random output stalls.
        for (int i = 0; i < 40; i++) begin
            f = rand_fe(i % 3);
            send(f);
            wait_out(1'b1, got);
            chk($sformatf("rand%0d", i), got, model(f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fe_tobytes_seq.md
Name: fe_tobytes_seq

Overview:
- Sequential encoder from the field-element limb domain to the canonical 32-byte wire encoding for GF(2^255-19).
- Consumes a 10-limb signed element: limb i occupies bits [32i+31:32i]; limb widths are 26,25,26,25,... bits, starting with 26 for limb 0.
- Produces the fully reduced little-endian byte string.
- Sits at the output of the field-op pipeline (after fe_neg/fe_add/fe_mul) and is the counterpart to the byte-to-limb decoder used on ingress.

Parameters:
- LIMBS_PER_CYCLE, 1, limbs processed per cycle in each carry phase. Legal values: 1, 2, 5. Phase length is PH = 10/LIMBS_PER_CYCLE cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_f is valid
- in_ready  output  1  block idle and able to accept
- in_f  input  320  signed limbs; precondition |limb_i| < 2^26
- out_valid  output  1  out_bytes valid
- out_ready  input  1  downstream accepts out_bytes
- out_bytes  output  256  canonical encoding; byte k at [8k+7:8k]; bit 255 always 0

Behaviour:
- Reset values (async, immediate): state=IDLE, in_ready=1, out_valid=0, out_bytes=0, internal limbs/q/counter=0.
- Handshake: transfer occurs on a clk edge where valid&&ready. in_ready=1 only in IDLE. out_valid holds, and out_bytes stays stable, until out_ready. No input is accepted while an output is pending.
- IDLE -> QCALC on accept:
  - Latch in_f into 10 limb registers.
  - Initialise q = (19*h9 + 2^24) >>> 25.
  - Clear the counter.
- QCALC (PH cycles):
  - For each limb i in order 0..9: q = (h_i + q) >>> w_i, with w_i = 26 for even i and 25 for odd i.
  - `>>>` is arithmetic (floor) shift. Internal width is 40-bit signed.
  - On the last step -> FOLD.
- FOLD (1 cycle):
  - h0 = h0 + 19*q; q ends in {0,1}.
  - -> CARRY.
- CARRY (PH cycles):
  - For each limb i in order: c = h_i >>> w_i; h_i -= c<<w_i; h_{i+1} += c (for i<9). c from h9 is discarded.
  - All results are non-negative and < 2^w_i.
  - On the last step -> OUT.
- OUT:
  - out_bytes = {1'b0, h9[24:0], h8[25:0], ..., h1[24:0], h0[25:0]} (255 bits packed LSB-first plus a zero MSB).
  - out_valid=1; on out_ready -> IDLE with in_ready=1 on the next cycle.
- Latency: out_valid rises exactly 2*PH+2 cycles after the accept edge (22 cycles for LIMBS_PER_CYCLE=1). Sustained throughput is one element per 2*PH+3 cycles with out_ready held high.
- Result is the unique value in [0, p-1]. Inputs equal to p, or in [p, 2^255), must reduce (e.g. p -> 0).
- Reset mid-operation: any state returns to IDLE and partial results are dropped. No out_valid pulse is produced for the aborted element.
- Inputs outside the precondition produce an undefined value but never hang: the FSM still returns to IDLE after the handshake.

Decomposition:
- Shared package fe_pkg:
  - NUM_LIMBS=10.
  - LIMB_W array {26,25,...}.
  - Limb bit-offset array {0,26,51,77,102,128,153,179,204,230}.
  - P_LIMBS constant.
  - Typedef fe_limbs_t (320-bit signed packed).
  - Typedef fe_bytes_t (256-bit).
- One natural sub-module: fe_carry_step. This is the combinational single-limb step: given h, carry-in and the width select, it returns carry-out and the reduced limb. It is instantiated LIMBS_PER_CYCLE times and shared between QCALC and CARRY.

Test Plan:
- All limbs 0 -> out_bytes = 0, out_valid 22 cycles after accept (LIMBS_PER_CYCLE=1).
- h0=1, others 0 -> out_bytes = 0x...0001 (byte0=0x01, rest 0x00).
- Limbs of p (h0=0x3FFFFED, odd limbs 0x1FFFFFF, even limbs 2..8 0x3FFFFFF) -> out_bytes = 0. Same with h0=0x3FFFFEE (p+1) -> out_bytes = 1.
- h0=-1 (0xFFFFFFFF), others 0 (output of fe_neg on one) -> byte0=0xEC, bytes1..30=0xFF, byte31=0x7F.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_bytes stable, in_valid held high is not accepted (in_ready=0); accept happens one cycle after out_ready handshake.
- Assert rst during CARRY step 5 -> out_valid=0 immediately, in_ready=1 after release; next input (h0=1) yields 0x01 with normal latency.
